// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
// The optional compare-only decode is enabled with the MC_CTRL_CMP_EN macro.
package mc_ctrl_fsm_pkg;

  // Controller sequencing states; values above S_UNKNOWN are unreachable.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_e;

  // ALUControl codes
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ResultSrc selects
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // Instruction classes from Op
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Data-processing cmd field values
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] REG_PC = 4'hF;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Instruction-field inputs and control strobes between the instruction
// register / datapath and the multicycle controller.
interface mc_ctrl_fsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       NextPC;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [1:0] ALUControl;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;

  // Controller side
  modport master (
    input  Op, Funct, Rd,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
           ImmSrc, RegSrc, ALUControl, FlagW, PCS, RegW, MemW
  );

  // Datapath / instruction-register side
  modport slave (
    output Op, Funct, Rd,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
           ImmSrc, RegSrc, ALUControl, FlagW, PCS, RegW, MemW
  );
endinterface

// File: rtl/mc_alu_dec.sv
// ALU decoder: maps cmd/S to ALUControl and raw FlagW while ALUOp is set.
// NoWrite is a property of the instruction and is decoded regardless of ALUOp
// so the writeback state can suppress RegW. MC_CTRL_CMP_EN adds CMP decode.
module mc_alu_dec
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [4:0] funct_cmd_s,  // Funct[4:1]=cmd, Funct[0]=S
  input  logic       alu_op,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w,
  output logic       no_write
);

  logic [3:0] cmd;
  logic       s_bit;

  assign cmd   = funct_cmd_s[4:1];
  assign s_bit = funct_cmd_s[0];

  // Operation and flag-update decode; unrecognised cmds fall back to ADD, no flags.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    alu_control = ALU_ADD;
    flag_w      = 2'b00;
    if (alu_op) begin
      case (cmd)
        CMD_ADD: begin alu_control = ALU_ADD; flag_w = {s_bit, s_bit};  end
        CMD_SUB: begin alu_control = ALU_SUB; flag_w = {s_bit, s_bit};  end
        CMD_AND: begin alu_control = ALU_AND; flag_w = {s_bit, 1'b0};   end
        CMD_ORR: begin alu_control = ALU_ORR; flag_w = {s_bit, 1'b0};   end
`ifdef MC_CTRL_CMP_EN
        CMD_CMP: begin alu_control = ALU_SUB; flag_w = {s_bit, s_bit};  end
`endif
        default: begin alu_control = ALU_ADD; flag_w = 2'b00;           end
      endcase
    end
  end

  // Compare-only instructions never write the register file.
`ifdef MC_CTRL_CMP_EN
  assign no_write = (cmd == CMD_CMP);
`else
  assign no_write = 1'b0;
`endif

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle ARM controller: sequences FETCH through writeback per instruction
// and emits raw (pre-CondEx) strobes. Optional MC_CTRL_CMP_EN enables CMP decode.
// STATE_W must be >= 4.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  mc_ctrl_fsm_if.master   bus
);

  logic [STATE_W-1:0] state_q, state_d;
  logic       alu_op;
  logic       no_write;
  logic       reg_w, mem_w, branch;
  logic       ir_write, adr_src, alu_src_a, next_pc;
  logic [1:0] alu_src_b, result_src;

  // State register; reset returns to FETCH immediately, even mid-instruction.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) state_q <= STATE_W'(S_FETCH);
    else       state_q <= state_d;
  end

  // ALU decode is active only in the two execute states.
  assign alu_op = (state_q == STATE_W'(S_EXECR)) || (state_q == STATE_W'(S_EXECI));

  mc_alu_dec u_alu_dec (
    .funct_cmd_s (bus.Funct[4:0]),
    .alu_op      (alu_op),
    .alu_control (bus.ALUControl),
    .flag_w      (bus.FlagW),
    .no_write    (no_write)
  );

  // Next-state and Moore strobe decode.
  always_comb begin
    state_d    = STATE_W'(S_FETCH);
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    result_src = RES_ALUOUT;
    next_pc    = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    case (state_q)
      STATE_W'(S_FETCH): begin
        ir_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        next_pc    = 1'b1;
        state_d    = STATE_W'(S_DECODE);
      end
      STATE_W'(S_DECODE): begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        case (bus.Op)
          OP_MEM:  state_d = STATE_W'(S_MEMADR);
          OP_DP:   state_d = bus.Funct[5] ? STATE_W'(S_EXECI) : STATE_W'(S_EXECR);
          OP_BR:   state_d = STATE_W'(S_BRANCH);
          default: state_d = STATE_W'(S_UNKNOWN);
        endcase
      end
      STATE_W'(S_MEMADR): begin
        alu_src_b = SRCB_IMM;
        state_d   = bus.Funct[0] ? STATE_W'(S_MEMREAD) : STATE_W'(S_MEMWRITE);
      end
      STATE_W'(S_MEMREAD): begin
        adr_src = 1'b1;
        state_d = STATE_W'(S_MEMWB);
      end
      STATE_W'(S_MEMWB): begin
        result_src = RES_RDATA;
        reg_w      = 1'b1;
      end
      STATE_W'(S_MEMWRITE): begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      STATE_W'(S_EXECR): begin
        alu_src_b = SRCB_REG;
        state_d   = STATE_W'(S_ALUWB);
      end
      STATE_W'(S_EXECI): begin
        alu_src_b = SRCB_IMM;
        state_d   = STATE_W'(S_ALUWB);
      end
      STATE_W'(S_ALUWB): begin
        reg_w = ~no_write;
      end
      STATE_W'(S_BRANCH): begin
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURES;
        branch     = 1'b1;
      end
      default: ;  // UNKNOWN and unreachable encodings: strobes low, back to FETCH
    endcase
  end

  assign bus.IRWrite   = ir_write;
  assign bus.AdrSrc    = adr_src;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ResultSrc = result_src;
  assign bus.NextPC    = next_pc;
  assign bus.RegW      = reg_w;
  assign bus.MemW      = mem_w;
  assign bus.ImmSrc    = bus.Op;
  assign bus.RegSrc    = {bus.Op == 2'b01, bus.Op == 2'b10};
  // A write to R15 redirects the PC, as does a branch.
  assign bus.PCS       = ((bus.Rd == REG_PC) && reg_w) || branch;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: the stimulus process pushes the expected
// per-cycle control vector of each instruction; a monitor pops and compares
// on every falling edge. Honours MC_CTRL_CMP_EN the same way as the RTL.
module tb_mc_ctrl_fsm;

  typedef struct packed {
    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       next_pc;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [1:0] alu_control;
    logic [1:0] flag_w;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mc_ctrl_fsm_if intf ();

  mc_ctrl_fsm #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf.master)
  );

  always #5 clk = ~clk;

  vec_t sb_q[$];
  vec_t plan_q[$];
  int   n_vectors = 0;
  int   n_miscompares = 0;
  int   cycle_no = 0;

  // Reference model: per-instruction list of expected control vectors.
  function automatic void plan(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
    vec_t base, v;
    logic [3:0] cmd;
    logic       s;
    logic [1:0] ctrl, flags;
    logic       nowrite;
    plan_q.delete();
    base = '0;
    base.imm_src = op;
    base.reg_src = {op == 2'd1, op == 2'd2};
    // fetch: PC+4 into PC, latch instruction
    v = base; v.ir_write = 1; v.alu_src_a = 1; v.alu_src_b = 2; v.result_src = 2; v.next_pc = 1;
    plan_q.push_back(v);
    // decode: PC+8 computed, register read
    v = base; v.alu_src_a = 1; v.alu_src_b = 2; v.result_src = 2;
    plan_q.push_back(v);
    case (op)
      2'd1: begin
        v = base; v.alu_src_b = 1; plan_q.push_back(v);
        if (funct[0]) begin
          v = base; v.adr_src = 1; plan_q.push_back(v);
          v = base; v.result_src = 1; v.reg_w = 1; v.pcs = (rd == 4'hF); plan_q.push_back(v);
        end else begin
          v = base; v.adr_src = 1; v.mem_w = 1; plan_q.push_back(v);
        end
      end
      2'd0: begin
        cmd = funct[4:1];
        s   = funct[0];
        ctrl = 2'd0; flags = 2'd0; nowrite = 1'b0;
        if (cmd == 4'd4)       begin ctrl = 2'd0; flags = {s, s};    end
        else if (cmd == 4'd2)  begin ctrl = 2'd1; flags = {s, s};    end
        else if (cmd == 4'd0)  begin ctrl = 2'd2; flags = {s, 1'b0}; end
        else if (cmd == 4'd12) begin ctrl = 2'd3; flags = {s, 1'b0}; end
`ifdef MC_CTRL_CMP_EN
        else if (cmd == 4'd10) begin ctrl = 2'd1; flags = {s, s}; nowrite = 1'b1; end
`endif
        v = base; v.alu_src_b = funct[5] ? 2'd1 : 2'd0; v.alu_control = ctrl; v.flag_w = flags;
        plan_q.push_back(v);
        v = base; v.reg_w = ~nowrite; v.pcs = (rd == 4'hF) && !nowrite;
        plan_q.push_back(v);
      end
      2'd2: begin
        v = base; v.alu_src_b = 1; v.result_src = 2; v.pcs = 1;
        plan_q.push_back(v);
      end
      default: begin
        plan_q.push_back(base);
      end
    endcase
  endfunction

  // Runs one instruction; optionally pulses reset during cycle rst_cycle.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct,
                           input logic [3:0] rd, input int rst_cycle);
    int i;
    bit pulsed;
    plan(op, funct, rd);
    intf.Op = op;
    intf.Funct = funct;
    intf.Rd = rd;
    i = 0;
    pulsed = 0;
    while (i < plan_q.size()) begin
      if (i == rst_cycle && !pulsed) begin
        reset = 1'b1;
        sb_q.push_back(plan_q[0]);
        pulsed = 1;
        @(negedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        i = 1;
      end else begin
        sb_q.push_back(plan_q[i]);
        @(posedge clk); #1;
        i++;
      end
    end
  endtask

  // Monitor: compares the DUT's current control vector with the scoreboard head.
  initial begin
    vec_t exp_v, got_v;
    forever begin
      @(negedge clk);
      cycle_no++;
      if (sb_q.size() > 0) begin
        exp_v = sb_q.pop_front();
        got_v.ir_write    = intf.IRWrite;
        got_v.adr_src     = intf.AdrSrc;
        got_v.alu_src_a   = intf.ALUSrcA;
        got_v.alu_src_b   = intf.ALUSrcB;
        got_v.result_src  = intf.ResultSrc;
        got_v.next_pc     = intf.NextPC;
        got_v.imm_src     = intf.ImmSrc;
        got_v.reg_src     = intf.RegSrc;
        got_v.alu_control = intf.ALUControl;
        got_v.flag_w      = intf.FlagW;
        got_v.pcs         = intf.PCS;
        got_v.reg_w       = intf.RegW;
        got_v.mem_w       = intf.MemW;
        n_vectors++;
        if (got_v !== exp_v) begin
          n_miscompares++;
          $display("FAIL ctrl_vec cycle %0d op=%b funct=%b rd=%h: got %b expected %b",
                   cycle_no, intf.Op, intf.Funct, intf.Rd, got_v, exp_v);
        end
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized instructions.
  initial begin
    int rc;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    intf.Op = 2'b00;
    intf.Funct = 6'd0;
    intf.Rd = 4'd0;
    @(posedge clk); #1;
    run_instr(2'b01, 6'b011001, 4'h3, 0);   // LDR, reset released during its FETCH
    run_instr(2'b01, 6'b011001, 4'h3, 3);   // LDR with reset in MEMREAD
    run_instr(2'b00, 6'b001001, 4'h1, -1);  // ADDS
    run_instr(2'b10, 6'b000000, 4'h0, -1);  // B
    run_instr(2'b00, 6'b000100, 4'hF, -1);  // SUB to R15
    run_instr(2'b00, 6'b110101, 4'h0, -1);  // CMP (immediate form)
    run_instr(2'b00, 6'b010101, 4'h2, -1);  // CMP register form
    run_instr(2'b01, 6'b011000, 4'h2, -1);  // STR
    run_instr(2'b00, 6'b101000, 4'h5, -1);  // ADD immediate
    run_instr(2'b00, 6'b000001, 4'h6, -1);  // ANDS
    run_instr(2'b00, 6'b011001, 4'h7, -1);  // ORRS
    run_instr(2'b00, 6'b001111, 4'h8, -1);  // unrecognised cmd
    run_instr(2'b11, 6'b111111, 4'h9, -1);  // undefined
    run_instr(2'b01, 6'b011001, 4'hF, -1);  // LDR to PC
    for (int k = 0; k < 200; k++) begin
      op    = 2'($urandom_range(0, 3));
      funct = 6'($urandom);
      rd    = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      rc    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : -1;
      run_instr(op, funct, rd, rc);
    end
    @(negedge clk); #1;
    n_vectors++;
    if (sb_q.size() != 0) begin
      n_miscompares++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
